// File: rtl/bus_rr_arbiter_mux_if.sv
// bus_rr_arbiter_mux_if: master-side request/bus bundle for bus_rr_arbiter_mux.
// master modport: drives m_req/m_addr/m_data/m_as_n/m_rw, sees m_grant and bus_*.
// slave modport: the arbiter, which returns m_grant, bus_addr/data/as_n/rw, timeout.
interface bus_rr_arbiter_mux_if #(
  parameter int N_MASTERS = 4,
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32
);
  logic [N_MASTERS-1:0] m_req;
  logic [N_MASTERS*ADDR_W-1:0] m_addr;
  logic [N_MASTERS*DATA_W-1:0] m_data;
  logic [N_MASTERS-1:0] m_as_n;
  logic [N_MASTERS-1:0] m_rw;
  logic [N_MASTERS-1:0] m_grant;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_data;
  logic bus_as_n;
  logic bus_rw;
  logic timeout;
  modport master (
    output m_req, m_addr, m_data, m_as_n, m_rw,
    input m_grant, bus_addr, bus_data, bus_as_n, bus_rw, timeout
  );
  modport slave (
    input m_req, m_addr, m_data, m_as_n, m_rw,
    output m_grant, bus_addr, bus_data, bus_as_n, bus_rw, timeout
  );
endinterface

// File: rtl/bus_rr_arbiter_mux.sv
// bus_rr_arbiter_mux: round-robin bus arbiter plus master-to-bus multiplexer.
// Ports: clk, reset (async, active-high), bus (bus_rr_arbiter_mux_if.slave):
//   m_req/m_addr/m_data/m_as_n/m_rw in, registered one-hot m_grant out,
//   bus_addr/bus_data/bus_as_n/bus_rw muxed from m_grant, timeout pulse out.
// Define BUS_ARB_TIMEOUT_EN to add the MAX_HOLD forced-release timer.
module bus_rr_arbiter_mux #(
  parameter int N_MASTERS = 4,
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32
`ifdef BUS_ARB_TIMEOUT_EN
  , parameter int MAX_HOLD = 16
`endif
) (
  input logic clk,
  input logic reset,
  bus_rr_arbiter_mux_if.slave bus
);
  localparam int IW = $clog2(N_MASTERS);
  typedef enum logic {IDLE, OWNED} state_t;
  state_t state;
  logic [N_MASTERS-1:0] grant, elig, rot, win_oh;
  logic [IW-1:0] last, win_idx;
  logic win_found, owner_req, expire, handover;
`ifdef BUS_ARB_TIMEOUT_EN
  localparam int HW = $clog2(MAX_HOLD + 1);
  logic [HW-1:0] hold;
  logic [N_MASTERS-1:0] mask;
  logic to_q;
  assign expire = state == OWNED && owner_req && hold == HW'(MAX_HOLD);
  assign elig = bus.m_req & ~mask & ~grant;
  assign bus.timeout = to_q;
`else
  assign expire = 1'b0;
  assign elig = bus.m_req & ~grant;
  assign bus.timeout = 1'b0;
`endif
  assign owner_req = |(bus.m_req & grant);
  assign handover = state == IDLE || !owner_req || expire;
  assign win_oh = N_MASTERS'(1) << win_idx;
  assign bus.m_grant = grant;
  // Rotate so bit j is master (last+1+j) mod N; the lowest set bit wins.
  always_comb begin
    rot = N_MASTERS'({elig, elig} >> (32'(last) + 32'd1));
    win_found = 1'b0;
    win_idx = '0;
    for (int j = N_MASTERS - 1; j >= 0; j--)
      if (rot[j]) begin
        win_found = 1'b1;
        win_idx = IW'((int'(last) + 1 + j) % N_MASTERS);
      end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      grant <= '0;
      last <= IW'(N_MASTERS - 1);
`ifdef BUS_ARB_TIMEOUT_EN
      hold <= '0;
      mask <= '0;
      to_q <= 1'b0;
`endif
    end else begin
      if (handover) begin
        state <= win_found ? OWNED : IDLE;
        grant <= win_found ? win_oh : '0;
        last <= win_found ? win_idx : last;
      end
`ifdef BUS_ARB_TIMEOUT_EN
      hold <= handover ? (win_found ? HW'(1) : '0) : hold + HW'(1);
      // A revoked owner stays masked until it is seen with req low.
      mask <= (mask & bus.m_req) | (expire ? grant : '0);
      to_q <= expire;
`endif
    end
  always_comb begin
    bus.bus_addr = '0;
    bus.bus_data = '0;
    bus.bus_as_n = 1'b1;
    bus.bus_rw = 1'b1;
    for (int i = 0; i < N_MASTERS; i++)
      if (grant[i]) begin
        bus.bus_addr = bus.m_addr[i*ADDR_W +: ADDR_W];
        bus.bus_data = bus.m_data[i*DATA_W +: DATA_W];
        bus.bus_as_n = bus.m_as_n[i];
        bus.bus_rw = bus.m_rw[i];
      end
  end
endmodule

// File: tb/tb_bus_rr_arbiter_mux.sv
// tb_bus_rr_arbiter_mux: scoreboard bench for bus_rr_arbiter_mux (honours BUS_ARB_TIMEOUT_EN).
module tb_bus_rr_arbiter_mux;
  localparam int N = 4;
  localparam int AW = 30;
  localparam int DW = 32;
  localparam int HOLD = 16;
  typedef struct {
    logic [N-1:0] grant;
    logic to;
    string name;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;
  exp_t q[$];
  logic [AW-1:0] addr_tab [N] = '{30'h0000_1000, 30'h0000_2004, 30'h0abc_0008, 30'h3fff_fffc};
  logic [DW-1:0] data_tab [N] = '{32'h1111_1111, 32'h2222_2222, 32'hcafe_f00d, 32'hdead_beef};
  logic [N-1:0] as_tab = 4'b0101;
  logic [N-1:0] rw_tab = 4'b0110;
  bus_rr_arbiter_mux_if #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) bif ();
  bus_rr_arbiter_mux #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bif)
  );
  always #5 clk = ~clk;
  task automatic cmp(string name, string what, logic [63:0] got, logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s %s got=%h want=%h", name, what, got, want);
    end
  endtask
  task automatic check_out(string name, logic [N-1:0] g, logic to);
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic ea_n;
    logic erw;
    ea = '0;
    ed = '0;
    ea_n = 1'b1;
    erw = 1'b1;
    for (int i = 0; i < N; i++)
      if (g[i]) begin
        ea = addr_tab[i];
        ed = data_tab[i];
        ea_n = as_tab[i];
        erw = rw_tab[i];
      end
    cmp(name, "grant", 64'(bif.m_grant), 64'(g));
    cmp(name, "addr", 64'(bif.bus_addr), 64'(ea));
    cmp(name, "data", 64'(bif.bus_data), 64'(ed));
    cmp(name, "as_n/rw", 64'({bif.bus_as_n, bif.bus_rw}), 64'({ea_n, erw}));
    cmp(name, "timeout", 64'(bif.timeout), 64'(to));
  endtask
  always @(negedge clk)
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check_out(e.name, e.grant, e.to);
    end
  task automatic cyc(logic [N-1:0] req, logic [N-1:0] g, logic to, string name);
    bif.m_req = req;
    @(posedge clk);
    #1;
    q.push_back('{grant: g, to: to, name: name});
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end
  initial begin
    bif.m_req = '0;
    bif.m_addr = {addr_tab[3], addr_tab[2], addr_tab[1], addr_tab[0]};
    bif.m_data = {data_tab[3], data_tab[2], data_tab[1], data_tab[0]};
    bif.m_as_n = as_tab;
    bif.m_rw = rw_tab;
    #1;
    check_out("reset", 4'b0000, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    @(posedge clk);
    #1;
    cyc(4'b0000, 4'b0000, 1'b0, "idle");
    cyc(4'b0001, 4'b0001, 1'b0, "first_m0");
    cyc(4'b1111, 4'b0001, 1'b0, "m0_hold");
    cyc(4'b1110, 4'b0010, 1'b0, "rr_m1");
    cyc(4'b1111, 4'b0010, 1'b0, "m1_hold");
    cyc(4'b1101, 4'b0100, 1'b0, "rr_m2");
    cyc(4'b1111, 4'b0100, 1'b0, "m2_hold");
    cyc(4'b1011, 4'b1000, 1'b0, "rr_m3");
    cyc(4'b1111, 4'b1000, 1'b0, "m3_hold");
    cyc(4'b0111, 4'b0001, 1'b0, "rr_wrap_m0");
    cyc(4'b0100, 4'b0100, 1'b0, "only_m2");
    cyc(4'b1101, 4'b0100, 1'b0, "m2_no_preempt");
    cyc(4'b1001, 4'b1000, 1'b0, "after2_m3");
    cyc(4'b0001, 4'b0001, 1'b0, "after3_m0");
    cyc(4'b0000, 4'b0000, 1'b0, "all_drop");
    cyc(4'b0000, 4'b0000, 1'b0, "stay_idle");
    cyc(4'b0100, 4'b0100, 1'b0, "idle_to_m2");
    cyc(4'b0010, 4'b0010, 1'b0, "m1_owns");
    cyc(4'b0010, 4'b0010, 1'b0, "m1_keeps");
    #6;
    reset = 1'b1;
    bif.m_req = '0;
    #1;
    check_out("reset_mid", 4'b0000, 1'b0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk);
    #1;
    cyc(4'b0011, 4'b0001, 1'b0, "post_reset_m0");
    cyc(4'b0110, 4'b0010, 1'b0, "hold_start_m1");
    for (int i = 0; i < HOLD - 1; i++) cyc(4'b0110, 4'b0010, 1'b0, "hold_m1");
`ifdef BUS_ARB_TIMEOUT_EN
    cyc(4'b0110, 4'b0100, 1'b1, "timeout_to_m2");
    cyc(4'b0110, 4'b0100, 1'b0, "timeout_one_pulse");
    cyc(4'b0010, 4'b0000, 1'b0, "m1_masked");
    cyc(4'b0000, 4'b0000, 1'b0, "m1_drop");
    cyc(4'b0010, 4'b0010, 1'b0, "m1_regrant");
`else
    for (int i = 0; i < 6; i++) cyc(4'b0110, 4'b0010, 1'b0, "hold_forever");
    cyc(4'b0100, 4'b0100, 1'b0, "release_to_m2");
`endif
    @(negedge clk);
    #1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
